// File: rtl/debug_access_sequencer_pkg.sv
// Shared types for the debug access sequencer and the debug/uP interconnect.
// Mode encodings, FSM states, host register offsets and STATUS bit positions.
package debug_pkg;

    typedef enum logic [2:0] {
        MODE_UP          = 3'b000,
        MODE_RD_EXT      = 3'b001,
        MODE_RD_INSTR    = 3'b010,
        MODE_WR_EXT      = 3'b011,
        MODE_WR_INSTR    = 3'b100,
        MODE_RD_PC       = 3'b101,
        MODE_RD_PC_NEXT  = 3'b110
    } dbg_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RELEASE = 3'd4
    } dbg_state_t;

    localparam logic [1:0] REG_CMD   = 2'd0;
    localparam logic [1:0] REG_ADDR  = 2'd1;
    localparam logic [1:0] REG_WDATA = 2'd2;
    localparam logic [1:0] REG_RDATA = 2'd3;

    localparam int STS_BUSY        = 0;
    localparam int STS_ERR_OP      = 1;
    localparam int STS_ERR_BUSY    = 2;
    localparam int STS_ERR_TIMEOUT = 3;
    localparam int STS_OP_LSB      = 4;

    function automatic logic op_valid(input logic [2:0] op);
        return (op != 3'b000) && (op != 3'b111);
    endfunction

    function automatic logic op_is_pc(input dbg_mode_t op);
        return (op == MODE_RD_PC) || (op == MODE_RD_PC_NEXT);
    endfunction

    function automatic logic op_is_read(input dbg_mode_t op);
        return (op == MODE_RD_EXT) || (op == MODE_RD_INSTR) || op_is_pc(op);
    endfunction

endpackage

// File: rtl/debug_access_sequencer_timeout.sv
// WAIT-state watchdog for the debug access sequencer; built only with DBG_TIMEOUT_EN.
// expired_o fires on the LIMIT-th consecutive enabled cycle.
`ifdef DBG_TIMEOUT_EN
module dbg_timeout_counter #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)       cnt_d = '0;
        else if (enable_i) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expired_o = enable_i && (cnt_q == CW'(LIMIT - 1));
endmodule
`endif

// File: rtl/debug_access_sequencer.sv
// Avalon-MM debug host port that sequences one debug/uP interconnect access per CMD write.
// Optional WAIT timeout enabled by defining DBG_TIMEOUT_EN.
module debug_access_sequencer
    import debug_pkg::*;
#(
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    avs_address,
    input  logic          avs_read,
    input  logic          avs_write,
    input  logic [DW-1:0] avs_writedata,
    output logic [DW-1:0] avs_readdata,
    output dbg_mode_t     mode,
    output logic [DW-1:0] debugAddress,
    output logic [DW-1:0] DEBUGWrite,
    output logic          chipselect_debug,
    input  logic [DW-1:0] dataReadDebug,
    input  logic          doneExt,
    input  logic          doneInstr,
    output logic          busy
);
    dbg_state_t    state_q, state_d;
    dbg_mode_t     op_q, op_d;
    logic [DW-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic          err_op_q, err_op_d, err_busy_q, err_busy_d, err_to_q, err_to_d;
    logic          seq_busy, target_done, timed_out;
    logic [DW-1:0] status;

    assign seq_busy = (state_q != ST_IDLE);

    always_comb begin
        unique case (op_q)
            MODE_RD_EXT, MODE_WR_EXT:     target_done = doneExt;
            MODE_RD_INSTR, MODE_WR_INSTR: target_done = doneInstr;
            default:                      target_done = 1'b0;
        endcase
    end

`ifdef DBG_TIMEOUT_EN
    dbg_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q != ST_WAIT),
        .enable_i  (state_q == ST_WAIT),
        .expired_o (timed_out)
    );
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_op_d   = err_op_q;
        err_busy_d = err_busy_q;
        err_to_d   = err_to_q;

        // Host side: anything but an RDATA write is refused while a sequence runs.
        if (avs_write && avs_address != REG_RDATA) begin
            if (seq_busy) begin
                err_busy_d = 1'b1;
            end else if (avs_address == REG_CMD) begin
                if (op_valid(avs_writedata[2:0])) begin
                    op_d       = dbg_mode_t'(avs_writedata[2:0]);
                    err_op_d   = 1'b0;
                    err_busy_d = 1'b0;
                    err_to_d   = 1'b0;
                    state_d    = ST_ISSUE;
                end else begin
                    err_op_d = 1'b1;
                end
            end else if (avs_address == REG_ADDR) begin
                addr_d = avs_writedata;
            end else begin
                wdata_d = avs_writedata;
            end
        end

        unique case (state_q)
            ST_ISSUE:   state_d = (op_is_pc(op_q) || target_done) ? ST_CAPTURE : ST_WAIT;
            ST_WAIT: begin
                if (target_done) begin
                    state_d = ST_CAPTURE;
                end else if (timed_out) begin
                    err_to_d = 1'b1;
                    state_d  = ST_RELEASE;
                end
            end
            ST_CAPTURE: begin
                if (op_is_read(op_q)) rdata_d = dataReadDebug;
                state_d = ST_RELEASE;
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= MODE_UP;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_op_q   <= 1'b0;
            err_busy_q <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_op_q   <= err_op_d;
            err_busy_q <= err_busy_d;
            err_to_q   <= err_to_d;
        end
    end

    always_comb begin
        status                                 = '0;
        status[STS_BUSY]                       = seq_busy;
        status[STS_ERR_OP]                     = err_op_q;
        status[STS_ERR_BUSY]                   = err_busy_q;
        status[STS_ERR_TIMEOUT]                = err_to_q;
        status[STS_OP_LSB+2:STS_OP_LSB]        = op_q;
    end

    always_comb begin
        avs_readdata = '0;
        if (avs_read) begin
            unique case (avs_address)
                REG_CMD:   avs_readdata = status;
                REG_ADDR:  avs_readdata = addr_q;
                REG_WDATA: avs_readdata = wdata_q;
                default:   avs_readdata = rdata_q;
            endcase
        end
    end

    assign mode = (state_q == ST_ISSUE || state_q == ST_WAIT || state_q == ST_CAPTURE)
                  ? op_q : MODE_UP;
    assign chipselect_debug = (state_q == ST_ISSUE);
    assign busy             = seq_busy;
    assign debugAddress     = addr_q;
    assign DEBUGWrite       = wdata_q;
endmodule
